// File: rtl/watch_core_rtc_if.sv
// rtl/watch_core_rtc_if.sv - control keys and display outputs of the RTC core
interface watch_core_rtc_if;
  logic       set_en;
  logic       alm_sel;
  logic       key_hr;
  logic       key_min;
  logic       mode12;
  logic       alm_en;
  logic       alm_ack;
  logic [3:0] dig_ht;
  logic [3:0] dig_ho;
  logic [3:0] dig_mt;
  logic [3:0] dig_mo;
  logic       pm;
  logic [5:0] sec_led;
  logic       tick_1hz;
  logic       alarm_hit;

  modport master (
    output set_en, alm_sel, key_hr, key_min, mode12, alm_en, alm_ack,
    input  dig_ht, dig_ho, dig_mt, dig_mo, pm, sec_led, tick_1hz, alarm_hit
  );

  modport slave (
    input  set_en, alm_sel, key_hr, key_min, mode12, alm_en, alm_ack,
    output dig_ht, dig_ho, dig_mt, dig_mo, pm, sec_led, tick_1hz, alarm_hit
  );
endinterface

// File: rtl/watch_core_rtc.sv
// rtl/watch_core_rtc.sv - hh:mm:ss real-time clock with set mode, autorepeat keys and alarm
module watch_core_rtc #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int REPEAT_DIV = 25_000_000,
  parameter int REPEAT_DLY = 50_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  watch_core_rtc_if.slave   bus_if
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RMAX = (REPEAT_DLY > REPEAT_DIV) ? REPEAT_DLY : REPEAT_DIV;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] DLY_CNT = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] DIV_CNT = RW'(REPEAT_DIV);

  logic [4:0]    hr_q, hr_d, alm_hr_q, alm_hr_d;
  logic [5:0]    min_q, min_d, alm_min_q, alm_min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          hit_q, hit_d;
  logic [1:0]    key_prev_q;
  logic [RW-1:0] rpt_cnt_q [2];
  logic [RW-1:0] rpt_cnt_d [2];
  logic [1:0]    rpt_on_q, rpt_on_d;
  logic [1:0]    keys;
  logic [1:0]    key_inc;
  logic          tick_fire;

  assign keys = {bus_if.key_min, bus_if.key_hr};
  assign tick_fire = !bus_if.set_en && (presc_q == PRESC_MAX);

  // A repeat counter of 0 means idle: a key already held when SET is entered never repeats.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rpt_cnt_d[k] = rpt_cnt_q[k];
      rpt_on_d[k]  = rpt_on_q[k];
      key_inc[k]   = 1'b0;
      if (!bus_if.set_en || !keys[k]) begin
        rpt_cnt_d[k] = '0;
        rpt_on_d[k]  = 1'b0;
      end else if (!key_prev_q[k]) begin
        key_inc[k]   = 1'b1;
        rpt_cnt_d[k] = RW'(1);
        rpt_on_d[k]  = 1'b0;
      end else if (rpt_cnt_q[k] != '0) begin
        if ((!rpt_on_q[k] && rpt_cnt_q[k] == DLY_CNT) ||
            (rpt_on_q[k] && rpt_cnt_q[k] == DIV_CNT)) begin
          key_inc[k]   = 1'b1;
          rpt_cnt_d[k] = RW'(1);
          rpt_on_d[k]  = 1'b1;
        end else begin
          rpt_cnt_d[k] = rpt_cnt_q[k] + RW'(1);
        end
      end
    end
  end

  always_comb begin
    hr_d      = hr_q;
    min_d     = min_q;
    sec_d     = sec_q;
    alm_hr_d  = alm_hr_q;
    alm_min_d = alm_min_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    hit_d     = hit_q;
    if (bus_if.set_en) begin
      presc_d = '0;
      sec_d   = '0;
      if (bus_if.alm_sel) begin
        if (key_inc[0]) alm_hr_d  = (alm_hr_q == 5'd23) ? 5'd0 : alm_hr_q + 5'd1;
        if (key_inc[1]) alm_min_d = (alm_min_q == 6'd59) ? 6'd0 : alm_min_q + 6'd1;
      end else begin
        if (key_inc[0]) hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        if (key_inc[1]) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end
    end else if (tick_fire) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (tick_fire && bus_if.alm_en && sec_d == 6'd0 &&
        min_d == alm_min_q && hr_d == alm_hr_q) begin
      hit_d = 1'b1;
    end
    if (bus_if.alm_ack || !bus_if.alm_en) hit_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      alm_hr_q   <= '0;
      alm_min_q  <= '0;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      hit_q      <= 1'b0;
      key_prev_q <= '0;
      rpt_on_q   <= '0;
      for (int k = 0; k < 2; k++) rpt_cnt_q[k] <= '0;
    end else begin
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      hit_q      <= hit_d;
      key_prev_q <= keys;
      rpt_on_q   <= rpt_on_d;
      for (int k = 0; k < 2; k++) rpt_cnt_q[k] <= rpt_cnt_d[k];
    end
  end

  // Display path: alarm hh:mm while editing it, otherwise the running time.
  logic [4:0] hr_sel, hr_disp;
  logic [5:0] min_sel;

  always_comb begin
    hr_sel  = (bus_if.set_en && bus_if.alm_sel) ? alm_hr_q : hr_q;
    min_sel = (bus_if.set_en && bus_if.alm_sel) ? alm_min_q : min_q;
    hr_disp = hr_sel;
    if (bus_if.mode12) begin
      if (hr_sel == 5'd0)      hr_disp = 5'd12;
      else if (hr_sel > 5'd12) hr_disp = hr_sel - 5'd12;
    end
  end

  assign bus_if.dig_ht    = 4'(hr_disp / 5'd10);
  assign bus_if.dig_ho    = 4'(hr_disp % 5'd10);
  assign bus_if.dig_mt    = 4'(min_sel / 6'd10);
  assign bus_if.dig_mo    = 4'(min_sel % 6'd10);
  assign bus_if.pm        = (hr_sel >= 5'd12);
  assign bus_if.sec_led   = sec_q;
  assign bus_if.tick_1hz  = tick_q;
  assign bus_if.alarm_hit = hit_q;
endmodule

// File: tb/tb_watch_core_rtc.sv
// tb/tb_watch_core_rtc.sv - randomized and directed bench for watch_core_rtc
module tb_watch_core_rtc;
  localparam int TD  = 4;
  localparam int DLY = 6;
  localparam int DIV = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  watch_core_rtc_if bus();

  watch_core_rtc #(.TICK_DIV(TD), .REPEAT_DIV(DIV), .REPEAT_DLY(DLY)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  // Reference: time of day in seconds, alarm in hours/minutes, key hold age in cycles.
  int m_tod, m_ahr, m_amin, m_presc, m_tick, m_hit;
  int m_prev [2];
  int m_age  [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_update();
    int keyv [2];
    int inc  [2];
    int hr, mn;
    keyv[0] = int'(bus.key_hr);
    keyv[1] = int'(bus.key_min);
    if (rst) begin
      m_tod = 0; m_ahr = 0; m_amin = 0; m_presc = 0; m_tick = 0; m_hit = 0;
      for (int k = 0; k < 2; k++) begin m_prev[k] = 0; m_age[k] = -1; end
      return;
    end
    m_tick = 0;
    for (int k = 0; k < 2; k++) begin
      inc[k] = 0;
      if (!bus.set_en || keyv[k] == 0) m_age[k] = -1;
      else if (m_prev[k] == 0) begin m_age[k] = 0; inc[k] = 1; end
      else if (m_age[k] >= 0) begin
        m_age[k]++;
        if (m_age[k] >= DLY && (m_age[k] - DLY) % DIV == 0) inc[k] = 1;
      end
      m_prev[k] = keyv[k];
    end
    if (bus.set_en) begin
      m_presc = 0;
      m_tod   = m_tod - m_tod % 60;
      if (bus.alm_sel) begin
        m_ahr  = (m_ahr + inc[0]) % 24;
        m_amin = (m_amin + inc[1]) % 60;
      end else begin
        hr = m_tod / 3600;
        mn = (m_tod / 60) % 60;
        m_tod = ((hr + inc[0]) % 24) * 3600 + ((mn + inc[1]) % 60) * 60;
      end
    end else if (m_presc == TD - 1) begin
      m_presc = 0;
      m_tick  = 1;
      m_tod   = (m_tod + 1) % 86400;
      if (bus.alm_en && m_tod == m_ahr * 3600 + m_amin * 60) m_hit = 1;
    end else begin
      m_presc++;
    end
    if (bus.alm_ack || !bus.alm_en) m_hit = 0;
  endtask

  task automatic model_compare();
    int dh, dm, disp;
    dh = (bus.set_en && bus.alm_sel) ? m_ahr : m_tod / 3600;
    dm = (bus.set_en && bus.alm_sel) ? m_amin : (m_tod / 60) % 60;
    disp = dh;
    if (bus.mode12) disp = (dh == 0) ? 12 : (dh > 12 ? dh - 12 : dh);
    check_eq("dig_h", int'({bus.dig_ht, bus.dig_ho}), (disp / 10) * 16 + disp % 10);
    check_eq("dig_m", int'({bus.dig_mt, bus.dig_mo}), (dm / 10) * 16 + dm % 10);
    check_eq("pm", int'(bus.pm), (dh >= 12) ? 1 : 0);
    check_eq("sec_led", int'(bus.sec_led), m_tod % 60);
    check_eq("tick_1hz", int'(bus.tick_1hz), m_tick);
    check_eq("alarm_hit", int'(bus.alarm_hit), m_hit);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    model_compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int which);
    if (which == 0) bus.key_hr = 1'b1; else bus.key_min = 1'b1;
    step();
    bus.key_hr  = 1'b0;
    bus.key_min = 1'b0;
    step();
  endtask

  task automatic do_reset();
    bus.set_en = 0; bus.alm_sel = 0; bus.key_hr = 0; bus.key_min = 0;
    bus.mode12 = 0; bus.alm_en = 0; bus.alm_ack = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic int hhmm();
    return int'({bus.dig_ht, bus.dig_ho, bus.dig_mt, bus.dig_mo});
  endfunction

  initial begin
    int ticks;
    do_reset();
    check_eq("rst_digits", hhmm(), 16'h0000);
    rst = 1'b1; bus.mode12 = 1'b1;
    step();
    check_eq("rst_digits12", hhmm(), 16'h1200);
    check_eq("rst_pm12", int'(bus.pm), 0);

    // 1: one minute of running
    do_reset();
    ticks = 0;
    for (int i = 0; i < 4 * 60; i++) begin
      step();
      ticks += int'(bus.tick_1hz);
    end
    check_eq("t1_ticks", ticks, 60);
    check_eq("t1_digits", hhmm(), 16'h0001);
    check_eq("t1_sec", int'(bus.sec_led), 0);

    // 2: 23:59:59 rollover, 12 h view
    do_reset();
    bus.set_en = 1'b1;
    step();
    for (int i = 0; i < 23; i++) press(0);
    for (int i = 0; i < 59; i++) press(1);
    bus.set_en = 1'b0;
    run(59 * 4);
    check_eq("t2_pre_digits", hhmm(), 16'h2359);
    check_eq("t2_pre_sec", int'(bus.sec_led), 59);
    bus.mode12 = 1'b1;
    run(4);
    check_eq("t2_tick", int'(bus.tick_1hz), 1);
    check_eq("t2_digits12", hhmm(), 16'h1200);
    check_eq("t2_pm", int'(bus.pm), 0);

    // 3: autorepeat and minute wrap without carry
    do_reset();
    bus.set_en = 1'b1;
    step();
    bus.key_min = 1'b1;
    run(15);
    bus.key_min = 1'b0;
    step();
    check_eq("t3_hold", int'({bus.dig_mt, bus.dig_mo}), 8'h04);
    press(1);
    check_eq("t3_repress", int'({bus.dig_mt, bus.dig_mo}), 8'h05);
    for (int i = 0; i < 5; i++) press(0);
    for (int i = 0; i < 54; i++) press(1);
    check_eq("t3_h5m59", hhmm(), 16'h0559);
    press(1);
    check_eq("t3_wrap", hhmm(), 16'h0500);

    // 4: set_en on the prescaler's last count
    do_reset();
    run(3);
    bus.set_en = 1'b1;
    step();
    check_eq("t4_no_tick", int'(bus.tick_1hz), 0);
    check_eq("t4_sec", int'(bus.sec_led), 0);
    bus.set_en = 1'b0;
    run(3);
    check_eq("t4_not_yet", int'(bus.tick_1hz), 0);
    step();
    check_eq("t4_first_tick", int'(bus.tick_1hz), 1);

    // 5: alarm at 00:02
    do_reset();
    bus.set_en = 1'b1; bus.alm_sel = 1'b1;
    step();
    press(1);
    press(1);
    check_eq("t5_alarm_view", hhmm(), 16'h0002);
    bus.set_en = 1'b0; bus.alm_sel = 1'b0; bus.alm_en = 1'b1;
    run(479);
    check_eq("t5_before", int'(bus.alarm_hit), 0);
    step();
    check_eq("t5_hit", int'(bus.alarm_hit), 1);
    check_eq("t5_hit_tick", int'(bus.tick_1hz), 1);
    check_eq("t5_hit_time", hhmm(), 16'h0002);
    run(10);
    check_eq("t5_sticky", int'(bus.alarm_hit), 1);
    bus.alm_ack = 1'b1;
    step();
    bus.alm_ack = 1'b0;
    check_eq("t5_ack", int'(bus.alarm_hit), 0);
    bus.alm_en = 1'b0; bus.set_en = 1'b1; bus.alm_sel = 1'b1;
    step();
    press(1);
    press(1);
    bus.set_en = 1'b0; bus.alm_sel = 1'b0;
    run(480);
    check_eq("t5_dis_time", hhmm(), 16'h0004);
    check_eq("t5_dis_hit", int'(bus.alarm_hit), 0);

    // 6: reset mid-autorepeat and mid-run
    do_reset();
    bus.set_en = 1'b1;
    step();
    bus.key_hr = 1'b1;
    run(8);
    rst = 1'b1;
    step();
    check_eq("t6_rpt_digits", hhmm(), 16'h0000);
    rst = 1'b0; bus.key_hr = 1'b0; bus.set_en = 1'b0;
    run(9);
    rst = 1'b1;
    step();
    check_eq("t6_run_sec", int'(bus.sec_led), 0);
    check_eq("t6_run_tick", int'(bus.tick_1hz), 0);
    rst = 1'b0;

    // Randomized soak against the reference
    bus.alm_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.set_en = ~bus.set_en;
      if ($urandom_range(0, 7) == 0)  bus.key_hr = ~bus.key_hr;
      if ($urandom_range(0, 7) == 0)  bus.key_min = ~bus.key_min;
      if ($urandom_range(0, 29) == 0) bus.alm_sel = ~bus.alm_sel;
      if ($urandom_range(0, 19) == 0) bus.mode12 = ~bus.mode12;
      if ($urandom_range(0, 99) == 0) bus.alm_en = ~bus.alm_en;
      bus.alm_ack = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
